delay_sched: RTL and testbench

DELAY_SCHED -- requirements
Module: delay_sched

---
 rtl/delay_sched_if.sv | 34 +++
 rtl/delay_sched.sv | 132 +++++++++++++
 tb/tb_delay_sched.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_sched_if.sv
// delay_sched_if
//   Bundles the request/grant signals of the shared delay counter.
//   Ports (by modport):
//     master : drives req, len; observes gnt, done, err, busy, cnt
//     slave  : observes req, len; drives gnt, done, err, busy, cnt
//   req  [NREQ]        per-requester level request, held until done
//   len  [NREQ*CBITS]  per-requester length, slice i = len[i*CBITS +: CBITS]
//   gnt  [NREQ]        one-hot owner of the counter
//   done [NREQ]        one-cycle completion pulse to the owner
//   err                one-cycle pulse on a rejected length
//   busy               scheduler is not idle
//   cnt  [CBITS]       current delay count
interface delay_sched_if #(
    parameter int NREQ  = 4,
    parameter int CBITS = 15
);
    logic [NREQ-1:0]       req;
    logic [NREQ*CBITS-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic                  busy;
    logic [CBITS-1:0]      cnt;

    modport master (
        output req, len,
        input  gnt, done, err, busy, cnt
    );

    modport slave (
        input  req, len,
        output gnt, done, err, busy, cnt
    );
endinterface

// File: rtl/delay_sched.sv
// delay_sched
//   Shares one delay counter among NREQ requesters. An idle scheduler picks
//   the next requester round-robin, checks its length, and then either runs
//   the counter for that many cycles (gnt high, then a done pulse) or
//   rejects the request with a one-cycle err pulse.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  delay_sched_if.slave (req, len in; gnt, done, err, busy, cnt out)
module delay_sched #(
    parameter int NREQ  = 4,
    parameter int CBITS = 15,
    parameter int DMAX  = 17500
) (
    input  logic          clk,
    input  logic          rst,
    delay_sched_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CBITS-1:0] DMAX_C = CBITS'(DMAX);

    typedef enum logic [1:0] {IDLE, RUN, DONE, REJ} state_t;

    state_t           r_state;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_done;
    logic             r_err;
    logic             r_busy;
    logic [CBITS-1:0] r_cnt;
    logic [CBITS-1:0] r_len;
    logic [IW-1:0]    r_ptr;

    logic             w_pickValid;
    logic [IW-1:0]    w_pickIdx;
    logic [NREQ-1:0]  w_pickOneHot;
    logic [CBITS-1:0] w_pickLen;
    logic             w_lenOk;
    logic             w_ownerReq;
    logic             w_lastCycle;

    // Round-robin search starting just after the last selected requester.
    // Walking the offsets from far to near lets the nearest hit win.
    always_comb begin
        w_pickValid = 1'b0;
        w_pickIdx   = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[(int'(r_ptr) + k) % NREQ]) begin
                w_pickValid = 1'b1;
                w_pickIdx   = IW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_pickOneHot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_pickOneHot[i] = (w_pickIdx == IW'(i));
        end
    end

    assign w_pickLen   = bus.len[int'(w_pickIdx)*CBITS +: CBITS];
    assign w_lenOk     = (w_pickLen != '0) && (w_pickLen <= DMAX_C);
    // The owner is whoever holds gnt, so its request is simply req masked by gnt.
    assign w_ownerReq  = |(bus.req & r_gnt);
    assign w_lastCycle = (r_cnt == r_len - 1'b1);

    // Single-process FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_ptr   <= IW'(NREQ - 1);
        end else begin
            r_done <= '0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pickValid) begin
                        r_ptr  <= w_pickIdx;
                        r_busy <= 1'b1;
                        if (w_lenOk) begin
                            r_state <= RUN;
                            r_len   <= w_pickLen;
                            r_cnt   <= '0;
                            r_gnt   <= w_pickOneHot;
                        end else begin
                            r_state <= REJ;
                            r_err   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // A dropped owner request takes priority over completion.
                    if (!w_ownerReq) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_lastCycle) begin
                        r_state <= DONE;
                        r_done  <= r_gnt;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE, REJ: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.busy = r_busy;
    assign bus.cnt  = r_cnt;
endmodule

// File: tb/tb_delay_sched.sv
// tb_delay_sched
//   Directed bench for delay_sched. A transaction-level model predicts the
//   outputs and is compared every falling edge; directed scenarios add
//   hand-computed literal expectations.
module tb_delay_sched;
    localparam int NREQ  = 4;
    localparam int CBITS = 15;
    localparam int DMAX  = 17500;

    logic clk = 1'b0;
    logic rst = 1'b1;

    delay_sched_if #(.NREQ(NREQ), .CBITS(CBITS)) bus ();

    delay_sched #(.NREQ(NREQ), .CBITS(CBITS), .DMAX(DMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the counter, how long it has run, and whether a done
    // or err pulse is showing this cycle.
    int mOwner   = -1;
    int mElapsed = 0;
    int mLen     = 0;
    int mDone    = -1;
    int mPtr     = NREQ - 1;
    bit mErr     = 1'b0;

    initial begin
        int j, l, base;
        bit found;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mOwner = -1; mElapsed = 0; mLen = 0; mDone = -1; mErr = 1'b0; mPtr = NREQ - 1;
            end else if (mDone >= 0 || mErr) begin
                mDone = -1;
                mErr  = 1'b0;
            end else if (mOwner >= 0) begin
                if (!bus.req[mOwner]) begin
                    mOwner = -1; mElapsed = 0;
                end else if (mElapsed + 1 == mLen) begin
                    mDone = mOwner; mOwner = -1; mElapsed = 0;
                end else begin
                    mElapsed++;
                end
            end else begin
                found = 1'b0;
                base  = mPtr;
                for (int k = 1; k <= NREQ; k++) begin
                    j = (base + k) % NREQ;
                    if (!found && bus.req[j]) begin
                        found = 1'b1;
                        mPtr  = j;
                        l     = int'(bus.len[j*CBITS +: CBITS]);
                        if (l >= 1 && l <= DMAX) begin
                            mOwner = j; mElapsed = 0; mLen = l;
                        end else begin
                            mErr = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Compare process: DUT against model on every falling edge.
    initial begin
        logic [NREQ-1:0] expGnt, expDone;
        forever begin
            @(negedge clk);
            expGnt  = '0;
            expDone = '0;
            if (mOwner >= 0) expGnt[mOwner] = 1'b1;
            if (mDone >= 0)  expDone[mDone] = 1'b1;
            checkOutput("gnt",  64'(bus.gnt),  64'(expGnt));
            checkOutput("done", 64'(bus.done), 64'(expDone));
            checkOutput("err",  64'(bus.err),  64'(mErr));
            checkOutput("busy", 64'(bus.busy), 64'(mOwner >= 0 || mDone >= 0 || mErr));
            checkOutput("cnt",  64'(bus.cnt),  64'((mOwner >= 0) ? mElapsed : 0));
            checkOutput("onehot", 64'($countones({bus.gnt, bus.done, bus.err}) <= 1), 64'(1));
        end
    end

    // Event statistics for the directed scenarios.
    int cyc = 0;
    int gntCycles[NREQ];
    int doneCount[NREQ];
    int errCount = 0;
    int cntPeak  = 0;
    int grantOwner[$];
    int grantStart[$];
    int grantEnd[$];
    logic [NREQ-1:0] prevGnt = '0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.gnt[i])  gntCycles[i]++;
                if (bus.done[i]) doneCount[i]++;
                if (bus.gnt[i] && !prevGnt[i]) begin
                    grantOwner.push_back(i);
                    grantStart.push_back(cyc);
                end
            end
            if (bus.gnt == '0 && prevGnt != '0) grantEnd.push_back(cyc);
            if (bus.err) errCount++;
            if (int'(bus.cnt) > cntPeak) cntPeak = int'(bus.cnt);
            prevGnt = bus.gnt;
        end
    end

    task automatic clearStats();
        for (int i = 0; i < NREQ; i++) begin
            gntCycles[i] = 0;
            doneCount[i] = 0;
        end
        errCount = 0;
        cntPeak  = 0;
        grantOwner.delete();
        grantStart.delete();
        grantEnd.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input int l0, input int l1, input int l2, input int l3);
        bus.req = r;
        bus.len = {CBITS'(l3), CBITS'(l2), CBITS'(l1), CBITS'(l0)};
    endtask

    task automatic doReset();
        applyStimulus('0, 0, 0, 0, 0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        clearStats();
    endtask

    int expOrder[5] = '{0, 1, 2, 3, 0};

    initial begin
        applyStimulus('0, 0, 0, 0, 0);
        tick(2);
        checkOutput("rst_gnt",  64'(bus.gnt),  64'(0));
        checkOutput("rst_busy", 64'(bus.busy), 64'(0));
        checkOutput("rst_cnt",  64'(bus.cnt),  64'(0));
        rst = 1'b0;
        clearStats();

        // Single requester, length 3; a later length change must not matter.
        applyStimulus(4'b0001, 3, 0, 0, 0);
        tick(1);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t1_gnt",  64'(bus.gnt),  64'(4'b0001));
            checkOutput("t1_cnt",  64'(bus.cnt),  64'(k));
            checkOutput("t1_done", 64'(bus.done), 64'(0));
            if (k == 1) applyStimulus(4'b0001, 7, 0, 0, 0);
            tick(1);
        end
        checkOutput("t1_done_pulse", 64'(bus.done), 64'(4'b0001));
        checkOutput("t1_gnt_off",    64'(bus.gnt),  64'(0));
        checkOutput("t1_busy_done",  64'(bus.busy), 64'(1));
        applyStimulus('0, 7, 0, 0, 0);
        tick(1);
        checkOutput("t1_done_off", 64'(bus.done), 64'(0));
        checkOutput("t1_busy_off", 64'(bus.busy), 64'(0));

        // All four requesting, length 2: rotation 0,1,2,3,0 with 2 idle cycles between.
        doReset();
        applyStimulus(4'b1111, 2, 2, 2, 2);
        tick(22);
        applyStimulus('0, 2, 2, 2, 2);
        tick(4);
        checkOutput("t2_grants", 64'(grantStart.size() >= 5 && grantEnd.size() >= 5), 64'(1));
        if (grantStart.size() >= 5 && grantEnd.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                checkOutput($sformatf("t2_owner%0d", k), 64'(grantOwner[k]), 64'(expOrder[k]));
                checkOutput($sformatf("t2_len%0d", k), 64'(grantEnd[k] - grantStart[k]), 64'(2));
                if (k < 4)
                    checkOutput($sformatf("t2_space%0d", k), 64'(grantStart[k+1] - grantStart[k]), 64'(4));
            end
        end

        // Rejected lengths: 0 then DMAX+1, three err pulses each.
        doReset();
        applyStimulus(4'b0100, 0, 0, 0, 0);
        tick(6);
        applyStimulus(4'b0100, 0, 0, DMAX + 1, 0);
        tick(6);
        applyStimulus('0, 0, 0, 0, 0);
        tick(3);
        checkOutput("t3_err",  64'(errCount), 64'(6));
        checkOutput("t3_gnt",  64'(gntCycles[0] + gntCycles[1] + gntCycles[2] + gntCycles[3]), 64'(0));
        checkOutput("t3_done", 64'(doneCount[0] + doneCount[1] + doneCount[2] + doneCount[3]), 64'(0));

        // Longest legal run.
        doReset();
        applyStimulus(4'b0010, 0, DMAX, 0, 0);
        tick(DMAX + 1);
        applyStimulus('0, 0, DMAX, 0, 0);
        tick(4);
        checkOutput("t4_gnt_cycles", 64'(gntCycles[1]), 64'(DMAX));
        checkOutput("t4_cnt_peak",   64'(cntPeak),      64'(DMAX - 1));
        checkOutput("t4_done",       64'(doneCount[1]), 64'(1));

        // Owner 1 drops at cnt=5; search resumes after 1, so 3 beats 0.
        doReset();
        applyStimulus(4'b0010, 4, 10, 4, 4);
        tick(6);
        checkOutput("t5_cnt5", 64'(bus.cnt), 64'(5));
        checkOutput("t5_gnt1", 64'(bus.gnt), 64'(4'b0010));
        applyStimulus(4'b1001, 4, 10, 4, 4);
        tick(1);
        checkOutput("t5_abort_gnt",  64'(bus.gnt),  64'(0));
        checkOutput("t5_abort_cnt",  64'(bus.cnt),  64'(0));
        checkOutput("t5_abort_busy", 64'(bus.busy), 64'(0));
        tick(1);
        checkOutput("t5_next_gnt", 64'(bus.gnt), 64'(4'b1000));
        applyStimulus('0, 4, 10, 4, 4);
        tick(3);
        checkOutput("t5_no_done", 64'(doneCount[0] + doneCount[1] + doneCount[2] + doneCount[3]), 64'(0));

        // Reset between edges during a run; pointer must return to NREQ-1.
        doReset();
        applyStimulus(4'b0011, 10, 10, 0, 0);
        tick(4);
        checkOutput("t6_gnt_run", 64'(bus.gnt), 64'(4'b0001));
        checkOutput("t6_cnt_run", 64'(bus.cnt), 64'(3));
        #3 rst = 1'b1;
        #1;
        checkOutput("t6_async_gnt",  64'(bus.gnt),  64'(0));
        checkOutput("t6_async_cnt",  64'(bus.cnt),  64'(0));
        checkOutput("t6_async_busy", 64'(bus.busy), 64'(0));
        tick(1);
        checkOutput("t6_hold_gnt", 64'(bus.gnt), 64'(0));
        #2 rst = 1'b0;
        #1;
        checkOutput("t6_release_gnt", 64'(bus.gnt), 64'(0));
        tick(1);
        checkOutput("t6_first_gnt", 64'(bus.gnt), 64'(4'b0001));
        checkOutput("t6_first_cnt", 64'(bus.cnt), 64'(0));
        applyStimulus('0, 10, 10, 0, 0);
        tick(3);
        checkOutput("t6_no_done", 64'(doneCount[0] + doneCount[1] + doneCount[2] + doneCount[3]), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
